// File: rtl/bkm_data_step_monitor.sv
// Monitor/scoreboard behind bkm_data_step: CSD -> binary over two stages, compared against a loaded FIFO.
// Define BKM_MON_ASSERT_EN for simulation-only mismatch printing and sticky-flag errors.
module bkm_data_step_monitor #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     srst,
  input  logic                     enable,
  input  logic                     dut_valid,
  input  logic [2*W-1:0]           X_n_csd,
  input  logic [2*W-1:0]           Y_n_csd,
  input  logic                     exp_push,
  input  logic [W-1:0]             exp_X,
  input  logic [W-1:0]             exp_Y,
  output logic                     exp_full,
  output logic [$clog2(DEPTH):0]   exp_count,
  output logic                     mon_valid,
  output logic [W-1:0]             mon_X,
  output logic [W-1:0]             mon_Y,
  output logic                     mismatch,
  output logic [15:0]              chk_cnt,
  output logic [15:0]              err_cnt,
  output logic                     ovf,
  output logic                     unf,
  output logic                     fmt_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0] mem_x [DEPTH];
  logic [W-1:0] mem_y [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  logic          s1_valid;
  logic [W-1:0]  s1_xp, s1_xn, s1_yp, s1_yn;

  logic [W-1:0]  x_p, x_n, y_p, y_n;
  logic          illegal;
  logic [W-1:0]  x_diff, y_diff;
  logic          fifo_empty, pop, push_ok, differ;

  // Split each digit stream into +1 and -1 position vectors; code 10 counts as 0.
  always_comb begin
    x_p     = '0;
    x_n     = '0;
    y_p     = '0;
    y_n     = '0;
    illegal = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      x_p[i] = (X_n_csd[2*i +: 2] == 2'b01);
      x_n[i] = (X_n_csd[2*i +: 2] == 2'b11);
      y_p[i] = (Y_n_csd[2*i +: 2] == 2'b01);
      y_n[i] = (Y_n_csd[2*i +: 2] == 2'b11);
      if (X_n_csd[2*i +: 2] == 2'b10 || Y_n_csd[2*i +: 2] == 2'b10)
        illegal = 1'b1;
    end
  end

  always_comb begin
    x_diff     = s1_xp - s1_xn;
    y_diff     = s1_yp - s1_yn;
    fifo_empty = (exp_count == '0);
    pop        = enable && s1_valid && !fifo_empty;
    push_ok    = enable && exp_push && (!exp_full || pop);
    differ     = (x_diff != mem_x[rd_ptr]) || (y_diff != mem_y[rd_ptr]);
  end

  assign exp_full = (exp_count == FULL_CNT);

  always_ff @(posedge clk) begin
    if (push_ok && !srst) begin
      mem_x[wr_ptr] <= exp_X;
      mem_y[wr_ptr] <= exp_Y;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      s1_valid  <= 1'b0;
      s1_xp     <= '0;
      s1_xn     <= '0;
      s1_yp     <= '0;
      s1_yn     <= '0;
      mon_valid <= 1'b0;
      mon_X     <= '0;
      mon_Y     <= '0;
      mismatch  <= 1'b0;
      chk_cnt   <= '0;
      err_cnt   <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      fmt_err   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      exp_count <= '0;
    end else if (srst) begin
      s1_valid  <= 1'b0;
      s1_xp     <= '0;
      s1_xn     <= '0;
      s1_yp     <= '0;
      s1_yn     <= '0;
      mon_valid <= 1'b0;
      mon_X     <= '0;
      mon_Y     <= '0;
      mismatch  <= 1'b0;
      chk_cnt   <= '0;
      err_cnt   <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      fmt_err   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      exp_count <= '0;
    end else if (enable) begin
      s1_valid <= dut_valid;
      if (dut_valid) begin
        s1_xp <= x_p;
        s1_xn <= x_n;
        s1_yp <= y_p;
        s1_yn <= y_n;
        if (illegal)
          fmt_err <= 1'b1;
      end

      mon_valid <= s1_valid;
      mismatch  <= 1'b0;
      if (s1_valid) begin
        mon_X <= x_diff;
        mon_Y <= y_diff;
        if (fifo_empty) begin
          unf <= 1'b1;
        end else begin
          if (chk_cnt != 16'hFFFF)
            chk_cnt <= chk_cnt + 16'd1;
          if (differ) begin
            mismatch <= 1'b1;
            if (err_cnt != 16'hFFFF)
              err_cnt <= err_cnt + 16'd1;
          end
        end
      end

      // Pop is decided on the pre-edge occupancy, so a push into an empty FIFO is never bypassed.
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (exp_push && !push_ok)
        ovf <= 1'b1;
      case ({push_ok, pop})
        2'b10:   exp_count <= exp_count + CW'(1);
        2'b01:   exp_count <= exp_count - CW'(1);
        default: exp_count <= exp_count;
      endcase
    end else begin
      mon_valid <= 1'b0;
      mismatch  <= 1'b0;
    end
  end

`ifdef BKM_MON_ASSERT_EN
  logic [W-1:0] last_exp_x, last_exp_y;
  logic         ovf_d, unf_d, fmt_d;

  always_ff @(posedge clk) begin
    if (pop) begin
      last_exp_x <= mem_x[rd_ptr];
      last_exp_y <= mem_y[rd_ptr];
    end
    ovf_d <= ovf;
    unf_d <= unf;
    fmt_d <= fmt_err;
    if (mismatch)
      $display("%0t bkm_data_step_monitor: mon_X=%0h mon_Y=%0h expected X=%0h Y=%0h",
               $time, mon_X, mon_Y, last_exp_x, last_exp_y);
    if (fmt_err && !fmt_d)
      $error("bkm_data_step_monitor: illegal CSD digit code");
    if (unf && !unf_d)
      $error("bkm_data_step_monitor: result with empty expected FIFO");
    if (ovf && !ovf_d)
      $error("bkm_data_step_monitor: expected push dropped, FIFO full");
  end
`else
  // Silent build: results are observable only through the ports and counters.
`endif

endmodule

// File: tb/tb_bkm_data_step_monitor.sv
// Bench for bkm_data_step_monitor (W=8, DEPTH=4): directed table, corner sequences, random vs. a queue-based model.
module tb_bkm_data_step_monitor;
  localparam int W     = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        srst = 1'b0;
  logic        enable = 1'b0;
  logic        dut_valid = 1'b0;
  logic [15:0] X_n_csd = '0;
  logic [15:0] Y_n_csd = '0;
  logic        exp_push = 1'b0;
  logic [7:0]  exp_X = '0;
  logic [7:0]  exp_Y = '0;
  logic        exp_full;
  logic [2:0]  exp_count;
  logic        mon_valid;
  logic [7:0]  mon_X, mon_Y;
  logic        mismatch;
  logic [15:0] chk_cnt, err_cnt;
  logic        ovf, unf, fmt_err;

  bkm_data_step_monitor #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .arst(arst), .srst(srst), .enable(enable), .dut_valid(dut_valid),
    .X_n_csd(X_n_csd), .Y_n_csd(Y_n_csd), .exp_push(exp_push), .exp_X(exp_X), .exp_Y(exp_Y),
    .exp_full(exp_full), .exp_count(exp_count), .mon_valid(mon_valid), .mon_X(mon_X),
    .mon_Y(mon_Y), .mismatch(mismatch), .chk_cnt(chk_cnt), .err_cnt(err_cnt),
    .ovf(ovf), .unf(unf), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: in-flight samples tagged with the enabled edge at which they compare.
  typedef struct { int due; logic [7:0] x; logic [7:0] y; } samp_t;
  samp_t       pipe[$];
  logic [15:0] expq[$];
  int          ecount;
  logic        m_mv, m_mm, m_ovf, m_unf, m_fmt;
  logic [7:0]  m_mx, m_my;
  int          m_chk, m_err;

  typedef struct {
    logic pu; logic [7:0] ex; logic [7:0] ey;
    logic dv; logic [15:0] xc; logic [15:0] yc;
    logic mv; logic [7:0] mx; logic [7:0] my; logic mm;
    int chk; int err; int cnt;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void conv(input logic [15:0] c, output logic [7:0] v, output logic bad_code);
    int acc = 0;
    bad_code = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] d;
      d = c[2*i +: 2];
      if (d == 2'b01)      acc += (1 << i);
      else if (d == 2'b11) acc -= (1 << i);
      else if (d == 2'b10) bad_code = 1'b1;
    end
    v = acc[7:0];
  endfunction

  function automatic logic [15:0] enc(input logic [7:0] v);
    logic [15:0] c = '0;
    for (int i = 0; i < 8; i++) c[2*i +: 2] = v[i] ? 2'b01 : 2'b00;
    return c;
  endfunction

  function automatic logic [15:0] rand_csd();
    logic [15:0] c = '0;
    for (int i = 0; i < 8; i++) begin
      int r = $urandom_range(0, 63);
      c[2*i +: 2] = (r == 0) ? 2'b10 : (r < 32) ? 2'b00 : (r < 48) ? 2'b01 : 2'b11;
    end
    return c;
  endfunction

  task automatic model_reset();
    pipe.delete();
    expq.delete();
    ecount = 0;
    m_mv = 0; m_mm = 0; m_ovf = 0; m_unf = 0; m_fmt = 0;
    m_mx = '0; m_my = '0; m_chk = 0; m_err = 0;
  endtask

  task automatic model_edge(input logic en, input logic sr, input logic dv, input logic [15:0] xc,
                            input logic [15:0] yc, input logic pu, input logic [7:0] ex,
                            input logic [7:0] ey);
    samp_t s;
    logic [15:0] e;
    logic [7:0] xv, yv;
    logic bx, by;
    if (!arst || sr) begin
      model_reset();
    end else if (!en) begin
      m_mv = 0;
      m_mm = 0;
    end else begin
      m_mv = 0;
      m_mm = 0;
      if (pipe.size() > 0 && pipe[0].due == ecount) begin
        s = pipe.pop_front();
        m_mv = 1; m_mx = s.x; m_my = s.y;
        if (expq.size() > 0) begin
          e = expq.pop_front();
          if (m_chk != 65535) m_chk++;
          if (e != {s.x, s.y}) begin
            m_mm = 1;
            if (m_err != 65535) m_err++;
          end
        end else begin
          m_unf = 1;
        end
      end
      if (pu) begin
        if (expq.size() < DEPTH) expq.push_back({ex, ey});
        else m_ovf = 1;
      end
      if (dv) begin
        conv(xc, xv, bx);
        conv(yc, yv, by);
        if (bx || by) m_fmt = 1;
        s.due = ecount + 1; s.x = xv; s.y = yv;
        pipe.push_back(s);
      end
      ecount++;
    end
  endtask

  task automatic check_all();
    check("mon_valid", mon_valid, m_mv);
    check("mon_X", mon_X, m_mx);
    check("mon_Y", mon_Y, m_my);
    check("mismatch", mismatch, m_mm);
    check("chk_cnt", chk_cnt, m_chk);
    check("err_cnt", err_cnt, m_err);
    check("exp_count", exp_count, expq.size());
    check("exp_full", exp_full, expq.size() == DEPTH);
    check("ovf", ovf, m_ovf);
    check("unf", unf, m_unf);
    check("fmt_err", fmt_err, m_fmt);
  endtask

  task automatic tick(input logic en, input logic sr, input logic dv, input logic [15:0] xc,
                      input logic [15:0] yc, input logic pu, input logic [7:0] ex,
                      input logic [7:0] ey);
    enable = en; srst = sr; dut_valid = dv; X_n_csd = xc; Y_n_csd = yc;
    exp_push = pu; exp_X = ex; exp_Y = ey;
    @(posedge clk);
    model_edge(en, sr, dv, xc, yc, pu, ex, ey);
    #1;
    check_all();
  endtask

  task automatic idle();
    tick(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  vec_t vt[6];
  int   pulses;
  int   chk0;

  initial begin
    model_reset();
    #12;
    check_all();
    arst = 1'b1;

    // Table: plan items 1 and 2 as per-cycle rows.
    vt[0] = '{1'b1, 8'h05, 8'hFF, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0, 0, 0, 1};
    vt[1] = '{1'b0, 8'h00, 8'h00, 1'b1, 16'h0011, 16'h0003, 1'b0, 8'h00, 8'h00, 1'b0, 0, 0, 1};
    vt[2] = '{1'b0, 8'h00, 8'h00, 1'b0, 16'h0000, 16'h0000, 1'b1, 8'h05, 8'hFF, 1'b0, 1, 0, 0};
    vt[3] = '{1'b1, 8'h07, 8'h00, 1'b0, 16'h0000, 16'h0000, 1'b0, 8'h05, 8'hFF, 1'b0, 1, 0, 1};
    vt[4] = '{1'b0, 8'h00, 8'h00, 1'b1, 16'h0043, 16'h0001, 1'b0, 8'h05, 8'hFF, 1'b0, 1, 0, 1};
    vt[5] = '{1'b0, 8'h00, 8'h00, 1'b0, 16'h0000, 16'h0000, 1'b1, 8'h07, 8'h01, 1'b1, 2, 1, 0};
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b0, vt[i].dv, vt[i].xc, vt[i].yc, vt[i].pu, vt[i].ex, vt[i].ey);
      check($sformatf("tbl%0d mon_valid", i), mon_valid, vt[i].mv);
      check($sformatf("tbl%0d mon_X", i), mon_X, vt[i].mx);
      check($sformatf("tbl%0d mon_Y", i), mon_Y, vt[i].my);
      check($sformatf("tbl%0d mismatch", i), mismatch, vt[i].mm);
      check($sformatf("tbl%0d chk_cnt", i), chk_cnt, vt[i].chk);
      check($sformatf("tbl%0d err_cnt", i), err_cnt, vt[i].err);
      check($sformatf("tbl%0d exp_count", i), exp_count, vt[i].cnt);
    end

    // Overfill the FIFO, then drain it with back-to-back matching results.
    for (int i = 0; i < 5; i++)
      tick(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 8'(i*3+1), 8'(i*5+2));
    check("ovfl exp_full", exp_full, 1'b1);
    check("ovfl exp_count", exp_count, 3'd4);
    check("ovfl ovf", ovf, 1'b1);
    chk0 = chk_cnt;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0, 1'b1, enc(8'(i*3+1)), enc(8'(i*5+2)), 1'b0, '0, '0);
      if (mon_valid) pulses++;
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      if (mon_valid) pulses++;
    end
    check("drain pulses", pulses, 4);
    check("drain chk_cnt", chk_cnt, chk0 + 4);
    check("drain exp_count", exp_count, 3'd0);
    check("drain err_cnt", err_cnt, 16'd1);

    // Result against an empty FIFO, then an illegal digit code.
    chk0 = chk_cnt;
    tick(1'b1, 1'b0, 1'b1, enc(8'h09), '0, 1'b0, '0, '0);
    idle();
    check("empty unf", unf, 1'b1);
    check("empty mon_valid", mon_valid, 1'b1);
    check("empty chk_cnt", chk_cnt, chk0);
    check("empty mismatch", mismatch, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 16'h0002, '0, 1'b0, '0, '0);
    idle();
    check("illegal fmt_err", fmt_err, 1'b1);
    check("illegal mon_X", mon_X, 8'h00);

    // Freeze with a sample parked in stage 1; inputs during the freeze are ignored.
    tick(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 8'h11, 8'h22);
    tick(1'b1, 1'b0, 1'b1, enc(8'h11), enc(8'h22), 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h5555, 1'b1, 8'hAA, 8'hBB);
      check("frozen mon_valid", mon_valid, 1'b0);
    end
    idle();
    check("resume mon_valid", mon_valid, 1'b1);
    check("resume mon_X", mon_X, 8'h11);
    check("resume mismatch", mismatch, 1'b0);

    // Synchronous reset wins over a low enable.
    tick(1'b1, 1'b0, 1'b1, enc(8'h33), '0, 1'b1, 8'h33, 8'h00);
    tick(1'b0, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    check("srst chk_cnt", chk_cnt, 16'd0);
    check("srst fmt_err", fmt_err, 1'b0);
    idle();
    check("srst flushed", mon_valid, 1'b0);

    // Asynchronous reset mid-pipeline with two entries queued.
    tick(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 8'h01, 8'h02);
    tick(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 8'h03, 8'h04);
    tick(1'b1, 1'b0, 1'b1, enc(8'h01), enc(8'h02), 1'b0, '0, '0);
    #2;
    arst = 1'b0;
    #1;
    model_reset();
    check_all();
    check("arst exp_count", exp_count, 3'd0);
    idle();
    arst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      check("post-arst mon_valid", mon_valid, 1'b0);
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic        en, sr, dv, pu;
      logic [7:0]  v, ex, ey;
      logic [15:0] xc, yc;
      en = ($urandom_range(0, 9) != 0);
      sr = ($urandom_range(0, 99) == 0);
      dv = $urandom_range(0, 1);
      pu = ($urandom_range(0, 4) < 2);
      v  = 8'($urandom_range(0, 3));
      ex = 8'($urandom_range(0, 3));
      ey = 8'($urandom_range(0, 3));
      xc = ($urandom_range(0, 1) == 0) ? enc(v) : rand_csd();
      yc = ($urandom_range(0, 1) == 0) ? enc(ex) : rand_csd();
      tick(en, sr, dv, xc, yc, pu, ex, ey);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bkm_data_step_monitor.md
# bkm_data_step_monitor

- Verification monitor and scoreboard placed directly downstream of `bkm_data_step`.
- Captures the step's CSD-encoded `X_n1` / `Y_n1` outputs on a valid strobe and converts them back to two's-complement binary through a 2-stage pipeline.
- Compares each converted result against an expected value popped from an internal FIFO that the testbench loads.
- Reports per-sample mismatches and running pass/error counts.

## Interface

Parameters:
- `W`, 64, binary data width; CSD buses are 2*W.
- `DEPTH`, 8, expected-value FIFO depth; power of two, minimum 2.

Ports:
- `clk`  in  1  clock.
- `arst`  in  1  asynchronous reset, active-low: asserted at 0, released at 1.
- `srst`  in  1  synchronous reset, active-high; same effect as `arst`.
- `enable`  in  1  high = block operates; low = all state frozen, all inputs ignored.
- `dut_valid`  in  1  `X_n_csd` / `Y_n_csd` hold a result this cycle.
- `X_n_csd`  in  2*W  CSD result X from `bkm_data_step`.
- `Y_n_csd`  in  2*W  CSD result Y from `bkm_data_step`.
- `exp_push`  in  1  push `{exp_X, exp_Y}` into the FIFO.
- `exp_X`  in  W  expected binary X.
- `exp_Y`  in  W  expected binary Y.
- `exp_full`  out  1  FIFO full.
- `exp_count`  out  clog2(DEPTH)+1  FIFO occupancy.
- `mon_valid`  out  1  `mon_X` / `mon_Y` valid; 1-cycle pulse.
- `mon_X`  out  W  converted X.
- `mon_Y`  out  W  converted Y.
- `mismatch`  out  1  1-cycle pulse with `mon_valid` when the compare failed.
- `chk_cnt`  out  16  number of compares performed.
- `err_cnt`  out  16  number of failed compares.
- `ovf`  out  1  sticky: push dropped because the FIFO was full.
- `unf`  out  1  sticky: result arrived while the FIFO was empty.
- `fmt_err`  out  1  sticky: illegal CSD digit code seen.

## Operation

- **CSD digit encoding:** digit i occupies bits [2i+1:2i].
  - 00 = 0, 01 = +1, 11 = -1.
  - 10 is illegal: it sets `fmt_err` and is treated as 0.
- **Conversion:**
  - P = vector of +1 digit positions; N = vector of -1 digit positions.
  - Result = (P - N) mod 2^W; two's-complement wrap, no saturation.
- **Stage 1:** on `enable & dut_valid`, register P and N for X and Y, a valid bit, and the illegal-code flag.
- **Stage 2:**
  - Compute P - N; register `mon_X`, `mon_Y` and `mon_valid`.
  - If the FIFO is non-empty: pop, compare both values, increment `chk_cnt`; on any difference also pulse `mismatch` and increment `err_cnt`.
  - If the FIFO is empty: set `unf`; no compare, no count change, `mismatch` stays 0.
- **Counters:** saturate at 16'hFFFF.
- **FIFO rules:**
  - A push is accepted if not full, or if a pop occurs in the same cycle.
  - A push while full with no pop is dropped and sets `ovf`.
  - No bypass: a push and a pop on an empty FIFO in the same cycle → the pop sees empty (`unf` set) and the push is stored.
  - Pointers wrap modulo DEPTH.
- **`enable` low:** pipeline registers, FIFO, counters and sticky flags all hold. `mon_valid` and `mismatch` are forced to 0.
- **Reset values** (`arst` low asynchronously, or `srst` high at an edge):
  - Pipeline valids = 0, `mon_X` = `mon_Y` = 0.
  - `mismatch` = 0, counters = 0, stickies = 0.
  - FIFO empty: `exp_count` = 0, `exp_full` = 0.
  - In-flight samples are discarded. `srst` has priority over `enable`.

## Timing

- Latency is 2 cycles: `dut_valid` sampled at edge t → `mon_valid`, `mon_X`, `mon_Y`, `mismatch` high during the cycle after edge t+1.
- Counter updates are visible in that same cycle.
- Full throughput: one result per cycle. No backpressure toward `bkm_data_step`.
- `exp_count` and `exp_full` are registered. They reflect pushes and pops from the previous edge.
- Sticky flags assert the cycle after the triggering event and clear only on reset.

## Configuration

- Macro: `BKM_MON_ASSERT_EN`.
- **Defined:** every mismatch prints time, `mon_X`/`mon_Y` and the expected values via `$display`. Any `fmt_err`, `unf` or `ovf` rising edge issues `$error`. Excluded from synthesis.
- **Undefined:** silent; results are reported only through the output ports and counters.

## Test plan

All scenarios use W=8, DEPTH=4.

1. Push (0x05, 0xFF); drive `X_n_csd` = 16'h0011, `Y_n_csd` = 16'h0003 with `dut_valid` → 2 cycles later `mon_X` = 0x05, `mon_Y` = 0xFF, `mismatch` = 0, `chk_cnt` = 1.
2. Push (0x07, 0x00); drive X = 16'h0043, Y = 16'h0001 → `mon_X` = 0x07, `mon_Y` = 0x01, `mismatch` = 1, `err_cnt` = 1.
3. Five pushes with no results → `exp_full` = 1, `exp_count` = 4, `ovf` = 1. Then 4 back-to-back valid results → 4 consecutive `mon_valid` pulses, `chk_cnt` = 4, `exp_count` = 0.
4. `dut_valid` with an empty FIFO → `unf` = 1 and `mon_valid` = 1, `chk_cnt` unchanged. Then X = 16'h0002 → `fmt_err` = 1, `mon_X` = 0x00.
5. `enable` low for 3 cycles with a sample in flight → no outputs. Re-enable → the sample emerges after its remaining stage.
6. `arst` low mid-pipeline with the FIFO holding 2 entries → all outputs, counters and stickies = 0, `exp_count` = 0, and no `mon_valid` after release.
